rsc2_dec_lapo_ctrl: RTL and testbench

RSC2_DEC_LAPO_CTRL -- requirements
Module: rsc2_dec_lapo_ctrl

---
 rtl/rsc2_dec_lapo_ctrl_pkg.sv | 21 ++
 rtl/rsc2_dec_val_dly.sv | 27 ++
 rtl/rsc2_dec_lapo_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rsc2_dec_lapo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsc2_dec_lapo_ctrl_pkg.sv
// rsc2 decoder shared types: Lapo controller FSM states and address/length types.
// Ports: none (package). Imported by rsc2_dec_lapo_ctrl and its sub-modules.
// The address/length types describe the default build width (cADDR_W duobits).
package rsc2_dec_lapo_ctrl_pkg;

  localparam int unsigned cADDR_W = 10;

  // duobit address and block length (same width: a length of 0 is legal)
  typedef logic [cADDR_W-1:0] addr_t;
  typedef logic [cADDR_W-1:0] len_t;
  // outstanding read count needs one extra bit
  typedef logic [cADDR_W:0]   outst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rsc2_dec_val_dly.sv
// rsc2 decoder valid delay line: clock-enabled shift register of pDEPTH stages.
// Ports: iclk/ireset (sync, active-low)/iclkena, ival in, oval = ival delayed
// pDEPTH enabled cycles. Reset clears every stage regardless of iclkena.
module rsc2_dec_val_dly #(
  parameter int pDEPTH = 1
) (
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  input  logic ival,
  output logic oval
);

  logic [pDEPTH-1:0] sr_q;

  // shift form works for pDEPTH = 1 without a special-case slice
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      sr_q <= '0;
    end else if (iclkena) begin
      sr_q <= (sr_q << 1) | pDEPTH'(ival);
    end
  end

  assign oval = sr_q[pDEPTH-1];

endmodule

// File: rtl/rsc2_dec_lapo_ctrl.sv
// rsc2 decoder Lapo controller: issues len gamma/state reads, tracks outstanding
// Lapo results, writes extrinsics in read order, pulses odone at end of block.
// Ports: iclk, ireset (sync active-low), iclkena, istart/ilen/ordy (block start),
//   ordaddr/ordval (memory reads), olapo_val/ilapo_val (Lapo datapath valid in/out),
//   owraddr/owrval (extrinsic writes), obusy/odone/oerr (status).
// Macro RSC2_DEC_LAPO_CTRL_BACKWARD_EN: addresses descend len-1..0 instead of 0..len-1.
module rsc2_dec_lapo_ctrl
  import rsc2_dec_lapo_ctrl_pkg::*;
#(
  parameter int pADDR_W   = cADDR_W,
  parameter int pMEM_LAT  = 1,   // 1..4
  parameter int pLAPO_LAT = 6
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  logic [pADDR_W-1:0] ilen,
  output logic               ordy,
  output logic [pADDR_W-1:0] ordaddr,
  output logic               ordval,
  output logic               olapo_val,
  input  logic               ilapo_val,
  output logic [pADDR_W-1:0] owraddr,
  output logic               owrval,
  output logic               obusy,
  output logic               odone,
  output logic               oerr
);

  // first write lands this many enabled cycles after the accepted istart
  localparam int unsigned unused_e2e_lat = pMEM_LAT + pLAPO_LAT + 1;

`ifdef RSC2_DEC_LAPO_CTRL_BACKWARD_EN
  localparam bit cBACKWARD = 1'b1;
`else
  localparam bit cBACKWARD = 1'b0;
`endif

  localparam logic [pADDR_W-1:0] cONE   = pADDR_W'(1);
  localparam logic [pADDR_W:0]   cONE_W = (pADDR_W+1)'(1);

  function automatic logic [pADDR_W-1:0] first_addr(input logic [pADDR_W-1:0] len);
    return cBACKWARD ? (len - cONE) : '0;
  endfunction

  function automatic logic [pADDR_W-1:0] addr_step(input logic [pADDR_W-1:0] a);
    return cBACKWARD ? (a - cONE) : (a + cONE);
  endfunction

  state_t             state_q;
  logic [pADDR_W-1:0] len_q;
  logic [pADDR_W-1:0] rd_cnt_q;   // reads issued, including the one on ordaddr
  logic [pADDR_W-1:0] wr_cnt_q;   // results accepted so far
  logic [pADDR_W-1:0] rdaddr_q;
  logic [pADDR_W-1:0] wraddr_q;
  logic [pADDR_W:0]   outst_q, outst_d;
  logic               rdval_q;
  logic               done_q;
  logic               err_q;

  logic active;
  logic rd_iss;
  logic wr_acc;
  logic spurious;
  logic last_wr;

  assign active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // a held ordval only counts as a read in an enabled cycle
  assign rd_iss   = rdval_q & iclkena;
  assign wr_acc   = ilapo_val & iclkena & active & (outst_q != '0);
  assign spurious = ilapo_val & iclkena & active & (outst_q == '0);
  assign last_wr  = wr_acc & (wr_cnt_q == (len_q - cONE));

  always_comb begin
    outst_d = outst_q;
    if (rd_iss && !wr_acc) begin
      outst_d = outst_q + cONE_W;
    end else if (!rd_iss && wr_acc) begin
      outst_d = outst_q - cONE_W;
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      rdaddr_q <= '0;
      wraddr_q <= '0;
      outst_q  <= '0;
      rdval_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (iclkena) begin
      outst_q <= outst_d;
      done_q  <= 1'b0;
      if (spurious) begin
        err_q <= 1'b1;
      end
      if (wr_acc) begin
        wr_cnt_q <= wr_cnt_q + cONE;
        wraddr_q <= addr_step(wraddr_q);
      end
      case (state_q)
        ST_IDLE: begin
          if (istart) begin
            len_q    <= ilen;
            wr_cnt_q <= '0;
            if (ilen != '0) begin
              state_q  <= ST_RUN;
              rdval_q  <= 1'b1;
              rdaddr_q <= first_addr(ilen);
              wraddr_q <= first_addr(ilen);
              rd_cnt_q <= cONE;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (rd_cnt_q == len_q) begin
            rdval_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            rdaddr_q <= addr_step(rdaddr_q);
            rd_cnt_q <= rd_cnt_q + cONE;
          end
        end
        ST_DRAIN: begin
          if (last_wr) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  rsc2_dec_val_dly #(
    .pDEPTH (pMEM_LAT)
  ) u_val_dly (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (rdval_q),
    .oval    (olapo_val)
  );

  assign ordy    = (state_q == ST_IDLE);
  assign obusy   = (state_q != ST_IDLE);
  assign ordval  = rdval_q;
  assign ordaddr = rdaddr_q;
  assign owrval  = wr_acc;
  assign owraddr = wraddr_q;
  assign odone   = done_q;
  assign oerr    = err_q;

endmodule

// File: tb/tb_rsc2_dec_lapo_ctrl.sv
// Directed bench for rsc2_dec_lapo_ctrl with a 6-cycle loopback Lapo model.
module tb_rsc2_dec_lapo_ctrl;

  logic       iclk;
  logic       ireset;
  logic       iclkena;
  logic       istart;
  logic [9:0] ilen;
  logic       ordy;
  logic [9:0] ordaddr;
  logic       ordval;
  logic       olapo_val;
  logic       ilapo_val;
  logic [9:0] owraddr;
  logic       owrval;
  logic       obusy;
  logic       odone;
  logic       oerr;

  logic       inj_val;
  logic [5:0] lapo_pipe;

  int n_cmp = 0;
  int n_bad = 0;

  rsc2_dec_lapo_ctrl dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .iclkena   (iclkena),
    .istart    (istart),
    .ilen      (ilen),
    .ordy      (ordy),
    .ordaddr   (ordaddr),
    .ordval    (ordval),
    .olapo_val (olapo_val),
    .ilapo_val (ilapo_val),
    .owraddr   (owraddr),
    .owrval    (owrval),
    .obusy     (obusy),
    .odone     (odone),
    .oerr      (oerr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Lapo datapath model: oval is ival delayed 6 enabled cycles
  always @(posedge iclk) begin
    if (!ireset) lapo_pipe <= '0;
    else if (iclkena) lapo_pipe <= {lapo_pipe[4:0], olapo_val};
  end
  assign ilapo_val = lapo_pipe[5] | inj_val;

  function automatic logic [9:0] exp_addr(input int len, input int k);
`ifdef RSC2_DEC_LAPO_CTRL_BACKWARD_EN
    return 10'(len - 1 - k);
`else
    return 10'(k);
`endif
  endfunction

  // leaves time at posedge+2; inputs are changed there, outputs checked 1 ns later
  task automatic tick;
    @(posedge iclk);
    #2;
  endtask

  task automatic test_reset;
    ireset = 1'b0; iclkena = 1'b0; istart = 1'b0; ilen = '0; inj_val = 1'b0;
    repeat (3) tick();
    #1;
    n_cmp++; if (ordy !== 1'b1)     begin n_bad++; $display("FAIL reset ordy got %0b want 1", ordy); end
    n_cmp++; if (ordval !== 1'b0)   begin n_bad++; $display("FAIL reset ordval got %0b want 0", ordval); end
    n_cmp++; if (olapo_val !== 1'b0) begin n_bad++; $display("FAIL reset olapo_val got %0b want 0", olapo_val); end
    n_cmp++; if (owrval !== 1'b0)   begin n_bad++; $display("FAIL reset owrval got %0b want 0", owrval); end
    n_cmp++; if (obusy !== 1'b0)    begin n_bad++; $display("FAIL reset obusy got %0b want 0", obusy); end
    n_cmp++; if (odone !== 1'b0)    begin n_bad++; $display("FAIL reset odone got %0b want 0", odone); end
    n_cmp++; if (oerr !== 1'b0)     begin n_bad++; $display("FAIL reset oerr got %0b want 0", oerr); end
    n_cmp++; if (ordaddr !== 10'd0) begin n_bad++; $display("FAIL reset ordaddr got %0d want 0", ordaddr); end
    n_cmp++; if (owraddr !== 10'd0) begin n_bad++; $display("FAIL reset owraddr got %0d want 0", owraddr); end
    ireset = 1'b1; iclkena = 1'b1;
    tick();
    tick();
  endtask

  // len=4 block: istart in cycle 0, optional extra istart / spurious ilapo_val cycles
  task automatic run_len4(input string tag, input int restart_cyc, input int inj_cyc);
    logic e_rv, e_lv, e_wv, e_done, e_rdy, e_err;
    for (int cyc = 0; cyc <= 14; cyc++) begin
      istart  = (cyc == 0) || (cyc == restart_cyc);
      ilen    = (cyc == 0) ? 10'd4 : 10'd7;
      inj_val = (cyc == inj_cyc);
      #1;
      e_rv   = (cyc >= 1) && (cyc <= 4);
      e_lv   = (cyc >= 2) && (cyc <= 5);
      e_wv   = (cyc >= 8) && (cyc <= 11);
      e_done = (cyc == 12);
      e_rdy  = (cyc == 0) || (cyc >= 13);
      e_err  = (inj_cyc >= 0) && (cyc > inj_cyc);
      n_cmp++; if (ordval !== e_rv)    begin n_bad++; $display("FAIL %s c%0d ordval got %0b want %0b", tag, cyc, ordval, e_rv); end
      n_cmp++; if (olapo_val !== e_lv) begin n_bad++; $display("FAIL %s c%0d olapo_val got %0b want %0b", tag, cyc, olapo_val, e_lv); end
      n_cmp++; if (owrval !== e_wv)    begin n_bad++; $display("FAIL %s c%0d owrval got %0b want %0b", tag, cyc, owrval, e_wv); end
      n_cmp++; if (odone !== e_done)   begin n_bad++; $display("FAIL %s c%0d odone got %0b want %0b", tag, cyc, odone, e_done); end
      n_cmp++; if (ordy !== e_rdy)     begin n_bad++; $display("FAIL %s c%0d ordy got %0b want %0b", tag, cyc, ordy, e_rdy); end
      n_cmp++; if (obusy !== !e_rdy)   begin n_bad++; $display("FAIL %s c%0d obusy got %0b want %0b", tag, cyc, obusy, !e_rdy); end
      n_cmp++; if (oerr !== e_err)     begin n_bad++; $display("FAIL %s c%0d oerr got %0b want %0b", tag, cyc, oerr, e_err); end
      if (e_rv) begin
        n_cmp++;
        if (ordaddr !== exp_addr(4, cyc - 1)) begin
          n_bad++; $display("FAIL %s c%0d ordaddr got %0d want %0d", tag, cyc, ordaddr, exp_addr(4, cyc - 1));
        end
      end
      if (e_wv) begin
        n_cmp++;
        if (owraddr !== exp_addr(4, cyc - 8)) begin
          n_bad++; $display("FAIL %s c%0d owraddr got %0d want %0d", tag, cyc, owraddr, exp_addr(4, cyc - 8));
        end
      end
      tick();
    end
    istart = 1'b0; inj_val = 1'b0;
  endtask

  task automatic test_basic;
    run_len4("basic", -1, -1);
  endtask

  task automatic test_start_during_run;
    run_len4("restart", 2, -1);
  endtask

  task automatic test_zero_len;
    for (int cyc = 0; cyc <= 3; cyc++) begin
      istart = (cyc == 0);
      ilen   = 10'd0;
      #1;
      n_cmp++; if (ordval !== 1'b0)          begin n_bad++; $display("FAIL zero c%0d ordval got %0b want 0", cyc, ordval); end
      n_cmp++; if (owrval !== 1'b0)          begin n_bad++; $display("FAIL zero c%0d owrval got %0b want 0", cyc, owrval); end
      n_cmp++; if (odone !== (cyc == 1))     begin n_bad++; $display("FAIL zero c%0d odone got %0b want %0b", cyc, odone, cyc == 1); end
      n_cmp++; if (ordy !== (cyc != 1))      begin n_bad++; $display("FAIL zero c%0d ordy got %0b want %0b", cyc, ordy, cyc != 1); end
      n_cmp++; if (obusy !== (cyc == 1))     begin n_bad++; $display("FAIL zero c%0d obusy got %0b want %0b", cyc, obusy, cyc == 1); end
      tick();
    end
    istart = 1'b0;
  endtask

  task automatic test_clkena;
    int  nr, nw, nd;
    bit  fin;
    nr = 0; nw = 0; nd = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
      iclkena = (cyc % 3) != 2;
      istart  = (cyc == 0);
      ilen    = 10'd8;
      #1;
      if (iclkena && ordval) begin
        n_cmp++;
        if (nr >= 8 || ordaddr !== exp_addr(8, nr)) begin
          n_bad++; $display("FAIL clkena read %0d ordaddr got %0d want %0d", nr, ordaddr, exp_addr(8, nr));
        end
        nr++;
      end
      if (owrval) begin
        n_cmp++;
        if (nw >= 8 || owraddr !== exp_addr(8, nw)) begin
          n_bad++; $display("FAIL clkena write %0d owraddr got %0d want %0d", nw, owraddr, exp_addr(8, nw));
        end
        nw++;
      end
      if (iclkena && odone) begin
        n_cmp++;
        if (nw != 8) begin n_bad++; $display("FAIL clkena writes_at_done got %0d want 8", nw); end
        nd++;
      end
      if (nd > 0 && ordy) fin = 1'b1;
      tick();
    end
    iclkena = 1'b1; istart = 1'b0;
    n_cmp++; if (!fin)     begin n_bad++; $display("FAIL clkena timeout got busy want idle"); end
    n_cmp++; if (nr != 8)  begin n_bad++; $display("FAIL clkena reads got %0d want 8", nr); end
    n_cmp++; if (nw != 8)  begin n_bad++; $display("FAIL clkena writes got %0d want 8", nw); end
    n_cmp++; if (nd != 1)  begin n_bad++; $display("FAIL clkena done_pulses got %0d want 1", nd); end
    n_cmp++; if (oerr !== 1'b0) begin n_bad++; $display("FAIL clkena oerr got %0b want 0", oerr); end
    tick();
  endtask

  task automatic test_error;
    // ilapo_val in IDLE: ignored
    inj_val = 1'b1;
    #1;
    n_cmp++; if (owrval !== 1'b0) begin n_bad++; $display("FAIL err_idle owrval got %0b want 0", owrval); end
    tick();
    inj_val = 1'b0;
    #1;
    n_cmp++; if (oerr !== 1'b0) begin n_bad++; $display("FAIL err_idle oerr got %0b want 0", oerr); end
    tick();
    // spurious result with nothing outstanding during RUN
    run_len4("err", -1, 1);
    #1;
    n_cmp++; if (oerr !== 1'b1) begin n_bad++; $display("FAIL err_sticky oerr got %0b want 1", oerr); end
    tick();
  endtask

  task automatic test_reset_mid;
    int bad_ev;
    istart = 1'b1; ilen = 10'd4;
    tick();
    istart = 1'b0;
    tick();
    ireset = 1'b0;
    tick();
    ireset = 1'b1;
    #1;
    n_cmp++; if (ordy !== 1'b1)      begin n_bad++; $display("FAIL rstmid ordy got %0b want 1", ordy); end
    n_cmp++; if (ordval !== 1'b0)    begin n_bad++; $display("FAIL rstmid ordval got %0b want 0", ordval); end
    n_cmp++; if (olapo_val !== 1'b0) begin n_bad++; $display("FAIL rstmid olapo_val got %0b want 0", olapo_val); end
    n_cmp++; if (owrval !== 1'b0)    begin n_bad++; $display("FAIL rstmid owrval got %0b want 0", owrval); end
    n_cmp++; if (obusy !== 1'b0)     begin n_bad++; $display("FAIL rstmid obusy got %0b want 0", obusy); end
    n_cmp++; if (odone !== 1'b0)     begin n_bad++; $display("FAIL rstmid odone got %0b want 0", odone); end
    n_cmp++; if (oerr !== 1'b0)      begin n_bad++; $display("FAIL rstmid oerr got %0b want 0", oerr); end
    n_cmp++; if (ordaddr !== 10'd0)  begin n_bad++; $display("FAIL rstmid ordaddr got %0d want 0", ordaddr); end
    n_cmp++; if (owraddr !== 10'd0)  begin n_bad++; $display("FAIL rstmid owraddr got %0d want 0", owraddr); end
    bad_ev = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      tick();
      #1;
      if (odone || owrval || ordval || !ordy) bad_ev++;
    end
    n_cmp++; if (bad_ev != 0) begin n_bad++; $display("FAIL rstmid abandoned_activity got %0d want 0", bad_ev); end
    tick();
  endtask

  initial begin
    ireset = 1'b0; iclkena = 1'b0; istart = 1'b0; ilen = '0; inj_val = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_start_during_run();
    test_clkena();
    test_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
